// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module : i2c_slave_regs
// Brief  : Oversampled I2C target exposing an 8-bit register bank with
//          auto-increment writes and repeated-start reads.
// Rev    : 1.0
// ============================================================================
module i2c_slave_regs #(
    parameter logic [6:0] CHIP_ADDR = 7'h39,
    parameter int         REG_DEPTH = 32,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oen,
    output logic       busy,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata
);
    localparam int         AW    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0] DEPTH = 9'(REG_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_REG       = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    state_t     state;
    logic [7:0] regs [REG_DEPTH];
    logic [7:0] ptr;
    logic [7:0] shift;
    logic [3:0] cnt;
    logic       rw;

    logic scl_m, scl_s, scl_h;
    logic sda_m, sda_s, sda_h;
    logic scl_rise, scl_fall, start, stop;
    logic [7:0] rx_byte, rd_cur, rd_nxt, host_val;

    function automatic logic [7:0] rd_reg(input logic [7:0] a);
        if ({1'b0, a} < DEPTH)
            return regs[a[AW-1:0]];
        return 8'hFF;
    endfunction

    // Sync flops idle high so leaving reset never looks like a bus edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            {scl_m, scl_s, scl_h} <= 3'b111;
            {sda_m, sda_s, sda_h} <= 3'b111;
        end else begin
            {scl_m, scl_s, scl_h} <= {scl_in, scl_m, scl_s};
            {sda_m, sda_s, sda_h} <= {sda_in, sda_m, sda_s};
        end
    end

    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;
    assign rx_byte  = {shift[6:0], sda_s};
    assign rd_cur   = rd_reg(ptr);
    assign rd_nxt   = rd_reg(ptr + 8'd1);
    assign host_val = rd_reg(host_addr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= 8'h00;
            shift      <= 8'h00;
            cnt        <= 4'd0;
            rw         <= 1'b0;
            sda_oen    <= 1'b1;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            host_rdata <= 8'h00;
            for (int i = 0; i < REG_DEPTH; i++)
                regs[i] <= RESET_VAL;
        end else begin
            wr_stb     <= 1'b0;
            host_rdata <= host_val;
            if (start) begin
                state   <= S_ADDR;
                cnt     <= 4'd0;
                sda_oen <= 1'b1;
                busy    <= 1'b0;
            end else if (stop) begin
                state   <= S_IDLE;
                sda_oen <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (rx_byte[7:1] == CHIP_ADDR) begin
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                state <= S_ADDR_ACK;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_REG: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt   <= 4'd0;
                            ptr   <= rx_byte;
                            state <= S_REG_ACK;
                        end
                    end
                    S_WDATA: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt     <= 4'd0;
                            wr_stb  <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= rx_byte;
                            if ({1'b0, ptr} < DEPTH)
                                regs[ptr[AW-1:0]] <= rx_byte;
                            ptr   <= ptr + 8'd1;
                            state <= S_WDATA_ACK;
                        end
                    end
                    // First fall in an ACK slot pulls SDA low, the second ends the slot.
                    S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (sda_oen) begin
                            sda_oen <= 1'b0;
                        end else begin
                            sda_oen <= 1'b1;
                            cnt     <= 4'd0;
                            if (state != S_ADDR_ACK) begin
                                state <= S_WDATA;
                            end else if (rw) begin
                                state   <= S_RDATA;
                                shift   <= rd_cur;
                                sda_oen <= rd_cur[7];
                            end else begin
                                state <= S_REG;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd0) begin
                                sda_oen <= shift[7];
                            end else if (cnt == 4'd8) begin
                                sda_oen <= 1'b1;
                                cnt     <= 4'd0;
                                state   <= S_RDATA_ACK;
                            end else begin
                                sda_oen <= shift[6];
                                shift   <= {shift[6:0], 1'b1};
                            end
                        end
                    end
                    S_RDATA_ACK: if (scl_rise) begin
                        if (!sda_s) begin
                            ptr   <= ptr + 8'd1;
                            shift <= rd_nxt;
                            cnt   <= 4'd0;
                            state <= S_RDATA;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                    S_IDLE, S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
